dtree_scheduler: RTL and testbench

Time-multiplexes one `dtree` classification engine across `CHANNELS` spike channels. Collects a `FEATURES`-sample feature vector per channel into a local buffer, selects complete channels by round-robin arbitration, and streams the selected vector into the engine one feature at a time under the engine's `ready` strobe. Captures the engine's `level`/`path` result and emits it tagged with the channel number. Sits between the per-channel feature extractors and the single shared `dtree` instance.

---
 rtl/dtree_scheduler.sv | 155 +++++++++++++++
 tb/tb_dtree_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_scheduler.sv
// Round-robin scheduler sharing one dtree engine across CHANNELS feature-vector buffers.
// Define DTREE_SCHED_DROP_COUNT_EN to add the saturating drop_count output.
module dtree_scheduler #(
  parameter int CHANNELS = 4,
  parameter int FEATURES = 3,
  parameter int IN_WIDTH = 10,
  localparam int CW = $clog2(CHANNELS),
  localparam int LW = $clog2(FEATURES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [CW-1:0]              in_channel,
  input  logic signed [IN_WIDTH-1:0] in_sample,
  output logic                       in_ready,
  input  logic                       eng_ready,
  output logic signed [IN_WIDTH-1:0] eng_sample,
  input  logic [LW-1:0]              eng_level,
  input  logic [LW-1:0]              eng_path,
  input  logic                       eng_valid,
  output logic                       res_valid,
  output logic [CW-1:0]              res_channel,
  output logic [LW-1:0]              res_level,
  output logic [LW-1:0]              res_path,
`ifdef DTREE_SCHED_DROP_COUNT_EN
  output logic [15:0]                drop_count,
`endif
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, EMIT} state_t;

  state_t                      state, state_nxt;
  logic signed [IN_WIDTH-1:0]  sample_buf [CHANNELS][FEATURES];
  logic [LW-1:0]               wr_idx [CHANNELS];
  logic [CHANNELS-1:0]         full;
  logic [CW-1:0]               rr_ptr, grant, pick, cand;
  logic                        pick_vld;
  logic [LW-1:0]               feat_idx;
  logic                        wr_en;
  logic                        last_feat;

  assign in_ready  = (int'(in_channel) < CHANNELS) && !full[in_channel];
  assign wr_en     = in_valid && in_ready;
  assign last_feat = (feat_idx == LW'(FEATURES - 1));
  assign res_valid = (state == EMIT);
  assign busy      = (state != IDLE);

  // Write pointers and full flags; a granted channel stays frozen until EMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= '0;
      for (int c = 0; c < CHANNELS; c++) wr_idx[c] <= '0;
    end else begin
      if (wr_en) begin
        if (wr_idx[in_channel] == LW'(FEATURES - 1)) begin
          full[in_channel]   <= 1'b1;
          wr_idx[in_channel] <= '0;
        end else begin
          wr_idx[in_channel] <= wr_idx[in_channel] + 1'b1;
        end
      end
      if (state == EMIT) full[grant] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) sample_buf[in_channel][wr_idx[in_channel]] <= in_sample;
  end

  // First full channel at or after rr_ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = CW'((int'(rr_ptr) + i) % CHANNELS);
      if (!pick_vld && full[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = FEED;
      FEED:    if (eng_ready && last_feat) state_nxt = WAIT;
      WAIT:    if (eng_valid) state_nxt = EMIT;
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Engine feed register and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant       <= '0;
      rr_ptr      <= '0;
      feat_idx    <= '0;
      eng_sample  <= '0;
      res_channel <= '0;
      res_level   <= '0;
      res_path    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant      <= pick;
            feat_idx   <= '0;
            eng_sample <= sample_buf[pick][0];
          end
        end
        FEED: begin
          if (eng_ready) begin
            if (last_feat) begin
              feat_idx   <= '0;
              eng_sample <= '0;
            end else begin
              feat_idx   <= LW'(feat_idx + 1'b1);
              eng_sample <= sample_buf[grant][LW'(feat_idx + 1'b1)];
            end
          end
        end
        WAIT: begin
          if (eng_valid) begin
            res_channel <= grant;
            res_level   <= eng_level;
            res_path    <= eng_path;
          end
        end
        EMIT: rr_ptr <= CW'((int'(grant) + 1) % CHANNELS);
        default: ;
      endcase
    end
  end

`ifdef DTREE_SCHED_DROP_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     drop_count <= '0;
    else if (in_valid && !in_ready) drop_count <= sat_inc16(drop_count);
  end
`endif

endmodule

// File: tb/tb_dtree_scheduler.sv
// Scoreboard bench for dtree_scheduler: directed vectors, engine handshakes, reset recovery.
module tb_dtree_scheduler;

  localparam int IW = 10;

  typedef struct packed {
    logic [1:0] ch;
    logic [1:0] lvl;
    logic [1:0] pth;
  } res_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [1:0]    in_channel;
  logic [IW-1:0] in_sample;
  logic          in_ready;
  logic          eng_ready;
  logic [IW-1:0] eng_sample;
  logic [1:0]    eng_level, eng_path;
  logic          eng_valid;
  logic          res_valid;
  logic [1:0]    res_channel, res_level, res_path;
  logic          busy;
`ifdef DTREE_SCHED_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  int   vec_cnt = 0;
  int   err_cnt = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  dtree_scheduler #(.CHANNELS(4), .FEATURES(3), .IN_WIDTH(IW)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_channel(in_channel),
    .in_sample(in_sample),
    .in_ready(in_ready),
    .eng_ready(eng_ready),
    .eng_sample(eng_sample),
    .eng_level(eng_level),
    .eng_path(eng_path),
    .eng_valid(eng_valid),
    .res_valid(res_valid),
    .res_channel(res_channel),
    .res_level(res_level),
    .res_path(res_path),
`ifdef DTREE_SCHED_DROP_COUNT_EN
    .drop_count(drop_count),
`endif
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [IW-1:0] s, input logic exp_rdy);
    in_valid   = 1'b1;
    in_channel = ch;
    in_sample  = s;
    #1;
    check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for a grant, then streams under a ready pattern (LSB first) until WAIT.
  task automatic feed_vector(input logic [IW-1:0] s0, input logic [IW-1:0] s1,
                             input logic [IW-1:0] s2, input logic [7:0] pat, input int exp_wait);
    logic [IW-1:0] s[3];
    int w = 0;
    int k = 0;
    int c = 0;
    s[0] = s0; s[1] = s1; s[2] = s2;
    while (!busy && w < 20) begin
      tick();
      w++;
    end
    check("grant_lat", w, exp_wait);
    if (!busy) return;
    while (k < 3 && c < 20) begin
      eng_ready = (c < 8) ? pat[c] : 1'b1;
      eng_valid = ~eng_ready;
      check("eng_smp", eng_sample, s[k]);
      tick();
      if (eng_ready) k++;
      c++;
    end
    eng_ready = 1'b0;
    eng_valid = 1'b0;
    check("eng_zero", eng_sample, 0);
    check("busy_wait", busy, 1);
  endtask

  task automatic finish_vector(input logic [1:0] ch, input logic [1:0] lvl, input logic [1:0] pth);
    exp_q.push_back({ch, lvl, pth});
    eng_valid = 1'b1;
    eng_level = lvl;
    eng_path  = pth;
    tick();
    eng_valid  = 1'b0;
    in_channel = ch;
    #1;
    check("busy_emit", busy, 1);
    check("rdy_emit", in_ready, 0);
    tick();
    check("res_cnt", exp_q.size(), 0);
    check("busy_idle", busy, 0);
    check("rdy_rel", in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("res_extra", 1, 0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("res_ch", res_channel, e.ch);
        check("res_lvl", res_level, e.lvl);
        check("res_pth", res_path, e.pth);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_channel = '0; in_sample = '0;
    eng_ready = 1'b0; eng_valid = 1'b0; eng_level = '0; eng_path = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_smp", eng_sample, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", res_valid, 0);
    check("rst_res", {res_channel, res_level, res_path}, 0);
    check("rst_rdy", in_ready, 1);
`ifdef DTREE_SCHED_DROP_COUNT_EN
    check("rst_drop", drop_count, 0);
`endif
    reset = 1'b0;
    tick();

    // single vector on ch2
    send(2, 10'h005, 1); send(2, 10'h3FF, 1); send(2, 10'h100, 1);
    feed_vector(10'h005, 10'h3FF, 10'h100, 8'hFF, 1);
    finish_vector(2, 1, 2);
    check("res_hold", {res_channel, res_level, res_path}, {2'd2, 2'd1, 2'd2});

    // ch3 occupies the engine while ch0/ch1 fill; ch1 then overflows
    send(3, 10'h011, 1); send(3, 10'h012, 1); send(3, 10'h013, 1);
    feed_vector(10'h011, 10'h012, 10'h013, 8'hFF, 1);
    send(0, 10'h020, 1); send(0, 10'h021, 1); send(0, 10'h022, 1);
    send(1, 10'h031, 1); send(1, 10'h032, 1); send(1, 10'h033, 1);
    send(1, 10'h2AA, 0);
`ifdef DTREE_SCHED_DROP_COUNT_EN
    check("drop_1", drop_count, 1);
`endif
    finish_vector(3, 2, 0);

    // ch0 with stalled engine; ch0 offers rejected in WAIT, ch3 refills
    feed_vector(10'h020, 10'h021, 10'h022, 8'hF9, 1);
    send(0, 10'h1AB, 0);
    send(3, 10'h041, 1); send(3, 10'h042, 1); send(3, 10'h043, 1);
    finish_vector(0, 0, 3);
`ifdef DTREE_SCHED_DROP_COUNT_EN
    check("drop_2", drop_count, 2);
`endif

    // ch1 next (rr_ptr=1), ch0 refills during its WAIT
    feed_vector(10'h031, 10'h032, 10'h033, 8'hFF, 1);
    send(0, 10'h051, 1); send(0, 10'h052, 1); send(0, 10'h053, 1);
    finish_vector(1, 3, 1);

    // rr_ptr=2 with ch0 and ch3 full: ch3 first, then ch0
    feed_vector(10'h041, 10'h042, 10'h043, 8'hFF, 1);
    finish_vector(3, 1, 1);
    feed_vector(10'h051, 10'h052, 10'h053, 8'hFF, 1);
    finish_vector(0, 2, 3);

    // reset in FEED after feature 1, with a partial vector pending on ch1
    send(1, 10'h061, 1); send(1, 10'h062, 1);
    send(2, 10'h071, 1); send(2, 10'h072, 1); send(2, 10'h073, 1);
    tick();
    check("rf_busy", busy, 1);
    check("rf_f0", eng_sample, 10'h071);
    eng_ready = 1'b1;
    tick();
    check("rf_f1", eng_sample, 10'h072);
    eng_ready  = 1'b0;
    reset      = 1'b1;
    in_channel = 2'd2;
    #1;
    check("rf_smp", eng_sample, 0);
    check("rf_busy0", busy, 0);
    check("rf_res", {res_channel, res_level, res_path}, 0);
    check("rf_rdy", in_ready, 1);
`ifdef DTREE_SCHED_DROP_COUNT_EN
    check("rf_drop", drop_count, 0);
`endif
    tick();
    reset = 1'b0;
    tick();
    send(1, 10'h081, 1); send(1, 10'h082, 1); send(1, 10'h083, 1);
    feed_vector(10'h081, 10'h082, 10'h083, 8'hFF, 1);
    finish_vector(1, 1, 0);
    repeat (4) tick();
    check("q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
